// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the VGA pixel stage.
// Fetch-side coordinates lead display-side hs/vs/de by FETCH_LAT clocks.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned H_FP      = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BP      = 160,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned V_FP      = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 29,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned FETCH_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] fetch_x,
  output logic [11:0] fetch_y,
  output logic        fetch_en,
  output logic        line_start,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic        de
);

  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SY0  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SY1  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);

  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SY0  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SY1  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

`ifndef SYNTHESIS
  initial begin
    assert (H_TOTAL <= 4095)
      else $error("H_TOTAL exceeds 12 bits");
    assert (V_TOTAL <= 4095)
      else $error("V_TOTAL exceeds 12 bits");
    assert (FETCH_LAT >= 1 && FETCH_LAT <= 8)
      else $error("FETCH_LAT out of range");
  end
`endif

  logic [11:0] h_cnt_q;
  logic [11:0] h_cnt_d;
  logic [11:0] v_cnt_q;
  logic [11:0] v_cnt_d;
  logic        h_wrap;
  logic        v_wrap;

  // Next raster position: h wraps every line, v steps on h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
    end
  end

  // Raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic act_d;
  logic hsr_d;
  logic vsr_d;
  logic ls_d;
  logic fs_d;

  // Region decodes of the current counter value.
  always_comb begin
    act_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsr_d = (h_cnt_q >= H_SY0) && (h_cnt_q < H_SY1);
    vsr_d = (v_cnt_q >= V_SY0) && (v_cnt_q < V_SY1);
    ls_d  = (h_cnt_q == 12'd0);
    fs_d  = ls_d && (v_cnt_q == 12'd0);
  end

  logic [11:0] fx_q;
  logic [11:0] fy_q;
  logic        fe_q;
  logic        ls_q;
  logic        fs_q;
  logic        hs_raw_q;
  logic        vs_raw_q;
  logic        de_raw_q;

  // Fetch-side outputs plus undelayed display levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      fx_q     <= '0;
      fy_q     <= '0;
      fe_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      hs_raw_q <= ~SYNC_POL;
      vs_raw_q <= ~SYNC_POL;
      de_raw_q <= 1'b0;
    end else begin
      fx_q     <= act_d ? h_cnt_q : 12'd0;
      fy_q     <= act_d ? v_cnt_q : 12'd0;
      fe_q     <= act_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      hs_raw_q <= hsr_d ? SYNC_POL : ~SYNC_POL;
      vs_raw_q <= vsr_d ? SYNC_POL : ~SYNC_POL;
      de_raw_q <= act_d;
    end
  end

  logic [FETCH_LAT-1:0] hs_dly_q;
  logic [FETCH_LAT-1:0] vs_dly_q;
  logic [FETCH_LAT-1:0] de_dly_q;

  // Delay line matching the colour lookup latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_dly_q <= {FETCH_LAT{~SYNC_POL}};
      vs_dly_q <= {FETCH_LAT{~SYNC_POL}};
      de_dly_q <= '0;
    end else begin
      hs_dly_q[0] <= hs_raw_q;
      vs_dly_q[0] <= vs_raw_q;
      de_dly_q[0] <= de_raw_q;
      for (int i = 1; i < FETCH_LAT; i++) begin
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
        de_dly_q[i] <= de_dly_q[i-1];
      end
    end
  end

  assign fetch_x     = fx_q;
  assign fetch_y     = fy_q;
  assign fetch_en    = fe_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign hs          = hs_dly_q[FETCH_LAT-1];
  assign vs          = vs_dly_q[FETCH_LAT-1];
  assign de          = de_dly_q[FETCH_LAT-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: bench for vga_timing_gen on a reduced raster.
// Expected values come from clocks elapsed since the last reset edge.
module tb_vga_timing_gen;

  localparam int HA  = 16;
  localparam int HF  = 3;
  localparam int HS  = 4;
  localparam int HB  = 5;
  localparam int VA  = 6;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int LAT = 3;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FR  = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] fetch_x;
  logic [11:0] fetch_y;
  logic        fetch_en;
  logic        line_start;
  logic        frame_start;
  logic        hs;
  logic        vs;
  logic        de;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .SYNC_POL (1'b0),
    .FETCH_LAT(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_x    (fetch_x),
    .fetch_y    (fetch_y),
    .fetch_en   (fetch_en),
    .line_start (line_start),
    .frame_start(frame_start),
    .hs         (hs),
    .vs         (vs),
    .de         (de)
  );

  typedef struct packed {
    logic [11:0] fx;
    logic [11:0] fy;
    logic        fe;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  // k = clock edges since the last edge that sampled rst high.
  function automatic exp_t model(input int k);
    exp_t e;
    int p;
    int h;
    int v;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (k >= 1) begin
      p = k - 1;
      h = p % HT;
      v = (p / HT) % VT;
      if (h < HA && v < VA) begin
        e.fe = 1'b1;
        e.fx = 12'(h);
        e.fy = 12'(v);
      end
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
    end
    if (k > LAT) begin
      p = k - 1 - LAT;
      h = p % HT;
      v = (p / HT) % VT;
      e.de = (h < HA) && (v < VA);
      e.hs = !(h >= HA + HF && h < HA + HF + HS);
      e.vs = !(v >= VA + VF && v < VA + VF + VS);
    end
    return e;
  endfunction

  task automatic tick(input logic r);
    rst = r;
    @(posedge clk);
    if (r) n = 0;
    else n = n + 1;
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick(1'b1);
    checks++;
    if (fetch_en !== 1'b0 || line_start !== 1'b0 ||
        frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b%b%b want 000",
               fetch_en, line_start, frame_start);
    end
    checks++;
    if (fetch_x !== 12'd0 || fetch_y !== 12'd0) begin
      errors++;
      $display("FAIL reset_xy got %0d,%0d want 0,0",
               fetch_x, fetch_y);
    end
    checks++;
    if (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0) begin
      errors++;
      $display("FAIL reset_disp got hs%b vs%b de%b want 110",
               hs, vs, de);
    end
  endtask

  task automatic test_reset_release;
    int cnt;
    tick(1'b0);
    checks++;
    if (fetch_en !== 1'b1 || line_start !== 1'b1 ||
        frame_start !== 1'b1) begin
      errors++;
      $display("FAIL release_strobes got %b%b%b want 111",
               fetch_en, line_start, frame_start);
    end
    checks++;
    if (fetch_x !== 12'd0 || fetch_y !== 12'd0 || de !== 1'b0) begin
      errors++;
      $display("FAIL release_xy got %0d,%0d de%b want 0,0 de0",
               fetch_x, fetch_y, de);
    end
    cnt = 0;
    while (de !== 1'b1 && cnt < 20) begin
      tick(1'b0);
      cnt++;
    end
    checks++;
    if (cnt != LAT) begin
      errors++;
      $display("FAIL de_lag got %0d want %0d", cnt, LAT);
    end
  endtask

  task automatic test_line_timing;
    int cnt;
    int per;
    int en;
    int xbad;
    cnt = 0;
    while (line_start !== 1'b1 && cnt < 2 * HT) begin
      tick(1'b0);
      cnt++;
    end
    en = 0;
    xbad = 0;
    per = 0;
    do begin
      if (fetch_en === 1'b1) begin
        if (fetch_x !== 12'(en)) xbad++;
        en++;
      end
      tick(1'b0);
      per++;
    end while (line_start !== 1'b1 && per < 2 * HT);
    checks++;
    if (per != HT) begin
      errors++;
      $display("FAIL line_period got %0d want %0d", per, HT);
    end
    checks++;
    if (en != HA || xbad != 0) begin
      errors++;
      $display("FAIL line_active got %0d bad %0d want %0d bad 0",
               en, xbad, HA);
    end
  endtask

  task automatic test_hsync;
    int cnt;
    int low;
    cnt = 0;
    while (hs !== 1'b0 && cnt < 2 * HT) begin
      tick(1'b0);
      cnt++;
    end
    checks++;
    if (cnt != HA + HF + LAT) begin
      errors++;
      $display("FAIL hs_fall got %0d want %0d", cnt, HA + HF + LAT);
    end
    low = 0;
    while (hs === 1'b0 && low < 2 * HT) begin
      tick(1'b0);
      low++;
    end
    checks++;
    if (low != HS) begin
      errors++;
      $display("FAIL hs_width got %0d want %0d", low, HS);
    end
  endtask

  task automatic test_frame;
    int cnt;
    int per;
    int vlow;
    int vfall;
    int lines;
    int maxy;
    logic pde;
    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 2 * FR) begin
      tick(1'b0);
      cnt++;
    end
    per = 0;
    vlow = 0;
    vfall = -1;
    lines = 0;
    maxy = 0;
    pde = de;
    do begin
      tick(1'b0);
      per++;
      if (vs === 1'b0) begin
        if (vfall < 0) vfall = per;
        vlow++;
      end
      if (de === 1'b1 && pde !== 1'b1) lines++;
      pde = de;
      if (fetch_en === 1'b1 && int'(fetch_y) > maxy)
        maxy = int'(fetch_y);
    end while (frame_start !== 1'b1 && per < 2 * FR);
    checks++;
    if (per != FR) begin
      errors++;
      $display("FAIL frame_period got %0d want %0d", per, FR);
    end
    checks++;
    if (vlow != VS * HT) begin
      errors++;
      $display("FAIL vs_width got %0d want %0d", vlow, VS * HT);
    end
    checks++;
    if (vfall != (VA + VF) * HT + LAT) begin
      errors++;
      $display("FAIL vs_start got %0d want %0d",
               vfall, (VA + VF) * HT + LAT);
    end
    checks++;
    if (lines != VA || maxy != VA - 1) begin
      errors++;
      $display("FAIL frame_lines got %0d maxy %0d want %0d maxy %0d",
               lines, maxy, VA, VA - 1);
    end
  endtask

  task automatic test_mid_reset;
    int cnt;
    int extra;
    int leak;
    cnt = 0;
    while (!(fetch_en === 1'b1 && fetch_x == 12'd10 &&
             fetch_y == 12'd3) && cnt < 2 * FR) begin
      tick(1'b0);
      cnt++;
    end
    checks++;
    if (cnt >= 2 * FR) begin
      errors++;
      $display("FAIL mid_reach got timeout want x10 y3");
    end
    tick(1'b1);
    checks++;
    if (de !== 1'b0 || hs !== 1'b1 || vs !== 1'b1) begin
      errors++;
      $display("FAIL mid_disp got hs%b vs%b de%b want 110",
               hs, vs, de);
    end
    checks++;
    if (fetch_en !== 1'b0 || line_start !== 1'b0 ||
        frame_start !== 1'b0 || fetch_x !== 12'd0) begin
      errors++;
      $display("FAIL mid_fetch got %b%b%b x%0d want 000 x0",
               fetch_en, line_start, frame_start, fetch_x);
    end
    tick(1'b0);
    checks++;
    if (frame_start !== 1'b1 || fetch_x !== 12'd0 ||
        fetch_y !== 12'd0) begin
      errors++;
      $display("FAIL mid_restart got fs%b %0d,%0d want fs1 0,0",
               frame_start, fetch_x, fetch_y);
    end
    leak = 0;
    extra = 0;
    for (int i = 1; i < FR; i++) begin
      tick(1'b0);
      if (i < LAT && de === 1'b1) leak++;
      if (frame_start === 1'b1) extra++;
    end
    checks++;
    if (leak != 0 || extra != 0) begin
      errors++;
      $display("FAIL mid_frame got leak %0d fs %0d want 0 0",
               leak, extra);
    end
    tick(1'b0);
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_next_fs got %b want 1", frame_start);
    end
  endtask

  task automatic test_scoreboard;
    exp_t e;
    exp_t g;
    int bad;
    logic r;
    bad = 0;
    for (int i = 0; i < 3 * FR + 1500; i++) begin
      r = (i > 3 * FR) && ($urandom_range(0, 149) == 0);
      tick(r);
      if (r && $urandom_range(0, 1) == 1) tick(1'b1);
      e = model(n);
      g = '{fx: fetch_x, fy: fetch_y, fe: fetch_en,
            ls: line_start, fs: frame_start,
            hs: hs, vs: vs, de: de};
      checks++;
      if (g !== e) begin
        errors++;
        if (bad < 10)
          $display("FAIL sb n=%0d got %h want %h", n, g, e);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_release;
    test_line_timing;
    test_hsync;
    test_frame;
    test_mid_reset;
    test_reset;
    test_scoreboard;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
